adc16dv160_input: RTL and testbench

- Capture block for the ADC16DV160 16-bit ADC data path.
- Takes deserialized 16-bit samples, already in the system clock domain, from the LVDS front-end.
- Packs sample pairs into 32-bit words and emits fixed-length packets on an AXI4-Stream master.
- Capture is triggered by an external sync pulse in real-time mode or by a software start bit; control and status are through an AXI4-Lite slave.

---
 rtl/adc16dv160_input.sv | 239 +++++++++++++++++++++++
 tb/tb_adc16dv160_input.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/adc16dv160_input.sv
// adc16dv160_input
// Capture block for the ADC16DV160 data path. Deserialized 16-bit samples
// (already in the m00_axis_aclk domain) are packed in pairs into 32-bit words
// and streamed out as fixed-length AXI4-Stream packets. A capture is started
// by a synchronized rising edge on sync (real-time mode) or by CR.START.
//
// Ports:
//   m00_axis_aclk / m00_axis_areset : clock, async active-high reset
//   adc_sample[15:0], adc_sample_valid : sample input, one per valid cycle
//   sync                              : async capture trigger
//   s_axi_*                           : AXI4-Lite slave (CR 0x0, SR 0x4, DSIZE 0x8)
//   m00_axis_*                        : AXI4-Stream master (32-bit, tkeep=F, tlast)
module adc16dv160_input #(
  parameter int unsigned DSIZE_DEFAULT = 1024,
  parameter int unsigned FIFO_DEPTH    = 16
) (
  input  logic        m00_axis_aclk,
  input  logic        m00_axis_areset,
  input  logic [15:0] adc_sample,
  input  logic        adc_sample_valid,
  input  logic        sync,
  input  logic [31:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [31:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic        m00_axis_tvalid,
  input  logic        m00_axis_tready,
  output logic [31:0] m00_axis_tdata,
  output logic [3:0]  m00_axis_tkeep,
  output logic        m00_axis_tlast
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, CAPTURE} state_t;

  logic clk, rst;
  assign clk = m00_axis_aclk;
  assign rst = m00_axis_areset;

  // ---------------- sync synchronizer + edge detect ----------------
  logic sync_meta_q, sync_ff_q, sync_prev_q, sync_rise;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta_q <= 1'b0;
      sync_ff_q   <= 1'b0;
      sync_prev_q <= 1'b0;
    end else begin
      sync_meta_q <= sync;
      sync_ff_q   <= sync_meta_q;
      sync_prev_q <= sync_ff_q;
    end
  end
  assign sync_rise = sync_ff_q & ~sync_prev_q;

  // ---------------- registers ----------------
  logic        cr_start_q, cr_rt_q, ovf_q;
  logic [31:0] dsize_q, dsize_eff;
  state_t      state_q;
  logic        half_q;
  logic [15:0] lo_q;
  logic [31:0] wcnt_q;

  // FIFO state
  logic [32:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          fifo_full, push, pop, drop, word_rdy, word_last, pkt_done;
  logic [32:0]   rd_word;

  assign dsize_eff = (dsize_q == 32'd0) ? 32'd1 : dsize_q;
  assign word_rdy  = (state_q == CAPTURE) && adc_sample_valid && half_q;
  assign fifo_full = (cnt_q == FULL_CNT);
  assign pop       = (cnt_q != '0) && m00_axis_tready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push      = word_rdy && (!fifo_full || pop);
  assign drop      = word_rdy && !push;
  assign word_last = (wcnt_q == dsize_eff - 32'd1);
  assign pkt_done  = push && word_last;

  // ---------------- AXI-Lite ----------------
  logic awready_q, bvalid_q, arready_q, rvalid_q, wr_hs, rd_hs, busy;
  logic [31:0] rdata_q, rd_mux;

  assign wr_hs = awready_q & s_axi_awvalid & s_axi_wvalid;
  assign rd_hs = arready_q & s_axi_arvalid;
  assign busy  = (state_q == CAPTURE) || (cnt_q != '0);

  always_comb begin
    rd_mux = 32'd0;
    case (s_axi_araddr[3:2])
      2'd0:    rd_mux = {29'd0, cr_rt_q, 1'b0, cr_start_q};
      2'd1:    rd_mux = {30'd0, ovf_q, busy};
      2'd2:    rd_mux = dsize_q;
      default: rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      awready_q <= s_axi_awvalid & s_axi_wvalid & ~awready_q & ~bvalid_q;
      if (wr_hs)
        bvalid_q <= 1'b1;
      else if (s_axi_bready)
        bvalid_q <= 1'b0;
      arready_q <= s_axi_arvalid & ~arready_q & ~rvalid_q;
      if (rd_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_mux;
      end else if (s_axi_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // Control/status registers. Ordering matters: a software write of START
  // overrides the end-of-packet clear, and a drop overrides an OVF clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cr_start_q <= 1'b0;
      cr_rt_q    <= 1'b0;
      ovf_q      <= 1'b0;
      dsize_q    <= 32'(DSIZE_DEFAULT);
    end else begin
      if (pkt_done)
        cr_start_q <= 1'b0;
      if (wr_hs) begin
        case (s_axi_awaddr[3:2])
          2'd0: if (s_axi_wstrb[0]) begin
            cr_start_q <= s_axi_wdata[0];
            cr_rt_q    <= s_axi_wdata[2];
          end
          2'd1: if (s_axi_wstrb[0] && s_axi_wdata[1])
            ovf_q <= 1'b0;
          2'd2: for (int b = 0; b < 4; b++)
            if (s_axi_wstrb[b]) dsize_q[8*b +: 8] <= s_axi_wdata[8*b +: 8];
          default: ;
        endcase
      end
      if (drop)
        ovf_q <= 1'b1;
    end
  end

  // ---------------- capture FSM + packer ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      half_q  <= 1'b0;
      lo_q    <= 16'd0;
      wcnt_q  <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          half_q <= 1'b0;
          wcnt_q <= 32'd0;
          if ((sync_rise && cr_rt_q) || cr_start_q)
            state_q <= CAPTURE;
        end
        CAPTURE: begin
          if (adc_sample_valid) begin
            if (!half_q) lo_q <= adc_sample;
            half_q <= ~half_q;
          end
          // Drops do not advance the count, so packets stay DSIZE long.
          if (push)
            wcnt_q <= wcnt_q + 32'd1;
          if (pkt_done)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // ---------------- output FIFO ----------------
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= {word_last, adc_sample, lo_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  assign rd_word = mem_q[rd_ptr_q];

  // ---------------- outputs ----------------
  assign s_axi_awready   = awready_q;
  assign s_axi_wready    = awready_q;
  assign s_axi_bresp     = 2'b00;
  assign s_axi_bvalid    = bvalid_q;
  assign s_axi_arready   = arready_q;
  assign s_axi_rdata     = rdata_q;
  assign s_axi_rresp     = 2'b00;
  assign s_axi_rvalid    = rvalid_q;
  // Gated by tvalid so everything reads 0 while empty / in reset.
  assign m00_axis_tvalid = (cnt_q != '0);
  assign m00_axis_tdata  = m00_axis_tvalid ? rd_word[31:0] : 32'd0;
  assign m00_axis_tlast  = m00_axis_tvalid & rd_word[32];
  assign m00_axis_tkeep  = {4{m00_axis_tvalid}};

  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr[31:4], s_axi_awaddr[1:0],
                              s_axi_araddr[31:4], s_axi_araddr[1:0]};

endmodule

// File: tb/tb_adc16dv160_input.sv
module tb_adc16dv160_input;
  logic        clk = 1'b0, rst = 1'b1;
  logic [15:0] adc_sample = '0;
  logic        adc_sample_valid = 1'b0, sync = 1'b0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rdata;
  logic [3:0]  wstrb = 4'hF, tkeep;
  logic        awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 1;
  logic        arvalid = 0, arready, rvalid, rready = 1;
  logic [1:0]  bresp, rresp;
  logic        tvalid, tready = 1'b1, tlast;
  logic [31:0] tdata;

  int total = 0, bad = 0;
  int mode = 0;          // 0: scoreboard data check, 1: packet length check
  int beat_cnt = 0, pkt_cnt = 0;
  logic [32:0] sb[$];    // expected {tlast, tdata}

  always #5 clk = ~clk;

  adc16dv160_input dut (
    .m00_axis_aclk(clk), .m00_axis_areset(rst),
    .adc_sample(adc_sample), .adc_sample_valid(adc_sample_valid), .sync(sync),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .m00_axis_tvalid(tvalid), .m00_axis_tready(tready), .m00_axis_tdata(tdata),
    .m00_axis_tkeep(tkeep), .m00_axis_tlast(tlast)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: consumes beats as the DUT presents them.
  always @(negedge clk) begin
    if (!rst && tvalid && tready) begin
      check("tkeep", 64'(tkeep), 64'hF);
      if (mode == 0) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL beat_unexpected: got 0x%0h want none", tdata);
        end else begin
          check("beat", 64'({tlast, tdata}), 64'(sb.pop_front()));
        end
      end else begin
        beat_cnt++;
        if (tlast) begin
          check("pkt_len", 64'(beat_cnt), 64'd1024);
          beat_cnt = 0;
          pkt_cnt++;
        end
      end
    end
  end

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d);
    int n;
    @(posedge clk); #1 awaddr = a; wdata = d; awvalid = 1; wvalid = 1;
    n = 0;
    while (n < 20) begin @(negedge clk); if (awready && wready) break; n++; end
    check("awready", 64'(awready), 64'd1);
    @(posedge clk); #1 awvalid = 0; wvalid = 0;
    n = 0;
    while (n < 20) begin @(negedge clk); if (bvalid) break; n++; end
    check("bvalid", 64'(bvalid), 64'd1);
    check("bresp", 64'(bresp), 64'd0);
    @(posedge clk);
  endtask

  task automatic axi_read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    int n;
    @(posedge clk); #1 araddr = a; arvalid = 1;
    n = 0;
    while (n < 20) begin @(negedge clk); if (arready) break; n++; end
    check("arready", 64'(arready), 64'd1);
    @(posedge clk); #1 arvalid = 0;
    n = 0;
    while (n < 20) begin @(negedge clk); if (rvalid) break; n++; end
    check("rvalid", 64'(rvalid), 64'd1);
    check("rresp", 64'(rresp), 64'd0);
    check(name, 64'(rdata), 64'(exp));
    @(posedge clk);
  endtask

  task automatic send(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 adc_sample = 16'(base + i); adc_sample_valid = 1;
    end
    @(posedge clk); #1 adc_sample_valid = 0;
  endtask

  task automatic pulse_sync(input int hi);
    @(posedge clk); #1 sync = 1;
    repeat (hi) @(posedge clk);
    #1 sync = 0;
    repeat (5) @(posedge clk);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || tvalid) && n < 3000) begin @(posedge clk); n++; end
    check("drain_left", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 64'(tvalid), 64'd0);
    check("rst_tdata", 64'(tdata), 64'd0);
    check("rst_bvalid", 64'(bvalid), 64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    rst = 0;

    // Register access
    axi_read_chk("dsize_rst", 32'h8, 32'd1024);
    axi_read_chk("sr_rst", 32'h4, 32'd0);
    axi_read_chk("unmapped", 32'hC, 32'd0);
    axi_write(32'hC, 32'hFFFF_FFFF);
    axi_read_chk("dsize_after_unmapped_wr", 32'h8, 32'd1024);
    axi_write(32'h0, 32'h4);
    axi_read_chk("cr_rt", 32'h0, 32'h4);

    // Real-time capture, DSIZE=4
    axi_write(32'h8, 32'd4);
    pulse_sync(3);
    axi_read_chk("sr_busy", 32'h4, 32'h1);
    sb.push_back({1'b0, 32'h0001_0000});
    sb.push_back({1'b0, 32'h0003_0002});
    sb.push_back({1'b0, 32'h0005_0004});
    sb.push_back({1'b1, 32'h0007_0006});
    send(0, 8);
    wait_drain();
    axi_read_chk("sr_idle", 32'h4, 32'h0);

    // Single-shot, DSIZE=2
    axi_write(32'h8, 32'd2);
    axi_write(32'h0, 32'h1);
    repeat (3) @(posedge clk);
    sb.push_back({1'b0, 32'h0011_0010});
    sb.push_back({1'b1, 32'h0013_0012});
    send(16'h10, 4);
    wait_drain();
    axi_read_chk("cr_start_clr", 32'h0, 32'h0);

    // Backpressure, DSIZE=64
    tready = 0;
    axi_write(32'h8, 32'd64);
    axi_write(32'h0, 32'h1);
    repeat (3) @(posedge clk);
    for (int k = 0; k < 16; k++) sb.push_back({1'b0, 16'(2*k+1), 16'(2*k)});
    for (int j = 0; j < 48; j++) sb.push_back({j == 47, 16'(129+2*j), 16'(128+2*j)});
    send(0, 128);
    axi_read_chk("sr_ovf_busy", 32'h4, 32'h3);
    @(posedge clk); #1 tready = 1;
    send(128, 96);
    wait_drain();
    axi_read_chk("sr_ovf", 32'h4, 32'h2);
    axi_write(32'h4, 32'h2);
    axi_read_chk("sr_ovf_clr", 32'h4, 32'h0);

    // Reset mid-packet
    tready = 0;
    axi_write(32'h8, 32'd8);
    axi_write(32'h0, 32'h4);
    pulse_sync(3);
    send(0, 6);
    @(negedge clk);
    check("tvalid_pre_rst", 64'(tvalid), 64'd1);
    @(posedge clk); #2 rst = 1;
    #1 check("tvalid_async_rst", 64'(tvalid), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 0; tready = 1;
    axi_read_chk("sr_after_rst", 32'h4, 32'h0);
    axi_read_chk("cr_after_rst", 32'h0, 32'h0);
    axi_read_chk("dsize_after_rst", 32'h8, 32'd1024);
    axi_write(32'h8, 32'd2);
    axi_write(32'h0, 32'h4);
    pulse_sync(3);
    sb.push_back({1'b0, 32'h0021_0020});
    sb.push_back({1'b1, 32'h0023_0022});
    send(16'h20, 4);
    wait_drain();

    // Repeated sync, DSIZE=1024, continuous samples, one extra mid-packet sync
    axi_write(32'h8, 32'd1024);
    mode = 1; beat_cnt = 0; pkt_cnt = 0;
    fork
      begin
        for (int i = 0; i < 11200; i++) begin
          @(posedge clk); #1 adc_sample = adc_sample + 16'd1; adc_sample_valid = 1;
        end
        @(posedge clk); #1 adc_sample_valid = 0;
      end
      begin
        for (int p = 0; p < 5; p++) begin
          repeat (10) @(posedge clk); #1 sync = 1;
          repeat (10) @(posedge clk); #1 sync = 0;
          if (p == 0) begin
            repeat (1000) @(posedge clk); #1 sync = 1;
            repeat (10) @(posedge clk); #1 sync = 0;
            repeat (1170) @(posedge clk);
          end else begin
            repeat (2180) @(posedge clk);
          end
        end
      end
    join
    repeat (20) @(posedge clk);
    check("pkt_cnt", 64'(pkt_cnt), 64'd5);
    check("beats_open", 64'(beat_cnt), 64'd0);
    axi_read_chk("sr_rep", 32'h4, 32'h0);
    mode = 0;
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
